// File: rtl/dmem_responder.sv
// Data-side memory responder: captures one dreq at a time, waits LATENCY cycles,
// then completes it with a one-cycle dresp_data_ok pulse against a byte-strobed 64-bit RAM.
module dmem_responder #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        dresp_err
);

  localparam int unsigned WORDS  = 1 << DEPTH_LOG2;
  localparam int unsigned ADDR_W = DEPTH_LOG2 + 3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  count;
  logic [63:0] holdAddr;
  logic [2:0]  holdSize;
  logic [7:0]  holdStrobe;
  logic [63:0] holdData;

  logic [63:0] mem [WORDS];

  logic [63:0]           selAddr;
  logic [2:0]            selSize;
  logic [2:0]            alignMask;
  logic                  selErr;
  logic [DEPTH_LOG2-1:0] selIdx;

  // In IDLE the live request is decoded so a zero-latency capture can respond next cycle
  always_comb begin
    selAddr   = holdAddr;
    selSize   = holdSize;
    alignMask = 3'd0;
    if (state == IDLE) begin
      selAddr = dreq_addr;
      selSize = dreq_size;
    end
    case (selSize)
      3'd1:    alignMask = 3'd1;
      3'd2:    alignMask = 3'd3;
      3'd3:    alignMask = 3'd7;
      default: alignMask = 3'd0;
    endcase
    selErr = (|(selAddr[2:0] & alignMask)) | (|selAddr[63:ADDR_W]) | (selSize > 3'd3);
    selIdx = selAddr[ADDR_W-1:3];
  end

  // Request FSM with registered response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      count         <= 4'd0;
      holdAddr      <= 64'd0;
      holdSize      <= 3'd0;
      holdStrobe    <= 8'd0;
      holdData      <= 64'd0;
      dresp_addr_ok <= 1'b0;
      dresp_data_ok <= 1'b0;
      dresp_data    <= 64'd0;
      dresp_err     <= 1'b0;
    end else begin
      dresp_addr_ok <= 1'b0;
      dresp_data_ok <= 1'b0;
      dresp_data    <= 64'd0;
      dresp_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (dreq_valid) begin
            holdAddr   <= dreq_addr;
            holdSize   <= dreq_size;
            holdStrobe <= dreq_strobe;
            holdData   <= dreq_data;
            count      <= 4'(LATENCY);
            if (LATENCY == 0) begin
              state         <= RESP;
              dresp_addr_ok <= 1'b1;
              dresp_data_ok <= 1'b1;
              dresp_err     <= selErr;
              dresp_data    <= selErr ? 64'd0 : mem[selIdx];
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state         <= RESP;
            dresp_addr_ok <= 1'b1;
            dresp_data_ok <= 1'b1;
            dresp_err     <= selErr;
            dresp_data    <= selErr ? 64'd0 : mem[selIdx];
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Store commits on the edge that ends RESP; contents survive reset
  always_ff @(posedge clk) begin
    if (state == RESP && !selErr) begin
      for (int i = 0; i < 8; i++) begin
        if (holdStrobe[i]) mem[selIdx][8*i +: 8] <= holdData[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (LATENCY 2, 0, 5) driven sequentially.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic [2:0]  dv;
  logic [63:0] da  [3];
  logic [2:0]  ds  [3];
  logic [7:0]  dst [3];
  logic [63:0] dd  [3];
  logic [2:0]  aok;
  logic [2:0]  okv;
  logic [2:0]  errv;
  logic [63:0] rdata [3];

  int cyc;
  int checks;
  int errors;

  typedef struct {
    int          inst;
    int          cyc;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  exp_t mexp;

  dmem_responder #(.LATENCY(2), .DEPTH_LOG2(10)) u0 (
    .clk(clk), .reset(rst), .dreq_valid(dv[0]), .dreq_addr(da[0]), .dreq_size(ds[0]),
    .dreq_strobe(dst[0]), .dreq_data(dd[0]), .dresp_addr_ok(aok[0]), .dresp_data_ok(okv[0]),
    .dresp_data(rdata[0]), .dresp_err(errv[0]));
  dmem_responder #(.LATENCY(0), .DEPTH_LOG2(10)) u1 (
    .clk(clk), .reset(rst), .dreq_valid(dv[1]), .dreq_addr(da[1]), .dreq_size(ds[1]),
    .dreq_strobe(dst[1]), .dreq_data(dd[1]), .dresp_addr_ok(aok[1]), .dresp_data_ok(okv[1]),
    .dresp_data(rdata[1]), .dresp_err(errv[1]));
  dmem_responder #(.LATENCY(5), .DEPTH_LOG2(10)) u2 (
    .clk(clk), .reset(rst), .dreq_valid(dv[2]), .dreq_addr(da[2]), .dreq_size(ds[2]),
    .dreq_strobe(dst[2]), .dreq_data(dd[2]), .dresp_addr_ok(aok[2]), .dresp_data_ok(okv[2]),
    .dresp_data(rdata[2]), .dresp_err(errv[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int latOf(input int inst);
    case (inst)
      0:       return 2;
      1:       return 0;
      default: return 5;
    endcase
  endfunction

  // Monitor: every response pops the scoreboard; idle outputs must be zero
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (okv[i]) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_data_ok inst %0d cyc %0d", i, cyc);
        end else begin
          mexp = sbq.pop_front();
          if (mexp.inst != i || mexp.cyc != cyc || aok[i] !== 1'b1 ||
              rdata[i] !== mexp.data || errv[i] !== mexp.err) begin
            errors++;
            $display("FAIL resp inst %0d cyc %0d addr_ok %b data %h err %b, required inst %0d cyc %0d addr_ok 1 data %h err %b",
                     i, cyc, aok[i], rdata[i], errv[i], mexp.inst, mexp.cyc, mexp.data, mexp.err);
          end
        end
      end else if (aok[i] !== 1'b0 || errv[i] !== 1'b0 || rdata[i] !== 64'd0) begin
        checks++;
        errors++;
        $display("FAIL idle_outputs inst %0d cyc %0d addr_ok %b err %b data %h, required all 0",
                 i, cyc, aok[i], errv[i], rdata[i]);
      end
    end
  end

  // Drive one request from the current cycle and hold it through its response
  task automatic issue(input int inst, input logic [63:0] addr, input logic [2:0] size,
                       input logic [7:0] strb, input logic [63:0] data,
                       input logic [63:0] expData, input logic expErr, input logic dropEarly);
    exp_t e;
    int   lat;
    lat = latOf(inst);
    dv[inst]  = 1'b1;
    da[inst]  = addr;
    ds[inst]  = size;
    dst[inst] = strb;
    dd[inst]  = data;
    e.inst = inst;
    e.cyc  = cyc + 1 + lat;
    e.data = expData;
    e.err  = expErr;
    sbq.push_back(e);
    for (int k = 0; k < 2 + lat; k++) begin
      @(posedge clk); #1;
      if (dropEarly && k == 0) begin
        dv[inst]  = 1'b0;
        da[inst]  = 64'hFFFF_FFFF_FFFF_FFFF;
        dst[inst] = 8'hFF;
        dd[inst]  = 64'd0;
      end
    end
    dv[inst]  = 1'b0;
    dst[inst] = 8'h00;
  endtask

  task automatic checkZero(input int inst, input string tag);
    checks++;
    if (aok[inst] !== 1'b0 || okv[inst] !== 1'b0 || errv[inst] !== 1'b0 || rdata[inst] !== 64'd0) begin
      errors++;
      $display("FAIL %s inst %0d addr_ok %b data_ok %b err %b data %h, required all 0",
               tag, inst, aok[inst], okv[inst], errv[inst], rdata[inst]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    dv = 3'b000;
    for (int i = 0; i < 3; i++) begin
      da[i] = 64'd0; ds[i] = 3'd0; dst[i] = 8'd0; dd[i] = 64'd0;
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) checkZero(i, "reset_state");
    rst = 1'b0;
    @(posedge clk); #1;

    // LATENCY=2: store/load ordering, errors, boundaries
    issue(0, 64'h28,   3'd3, 8'hFF, 64'h1122334455667788, 64'h0,                 1'b0, 1'b0);
    issue(0, 64'h28,   3'd3, 8'h00, 64'h0,                64'h1122334455667788, 1'b0, 1'b0);
    issue(0, 64'h28,   3'd3, 8'h0F, 64'hAAAAAAAABBBBBBBB, 64'h1122334455667788, 1'b0, 1'b0);
    issue(0, 64'h28,   3'd3, 8'h00, 64'h0,                64'h11223344BBBBBBBB, 1'b0, 1'b0);
    issue(0, 64'h2C,   3'd3, 8'h00, 64'h0,                64'h0,                 1'b1, 1'b0);
    issue(0, 64'h2C,   3'd3, 8'hFF, 64'hDEADBEEFDEADBEEF, 64'h0,                 1'b1, 1'b0);
    issue(0, 64'h28,   3'd3, 8'h00, 64'h0,                64'h11223344BBBBBBBB, 1'b0, 1'b0);
    issue(0, 64'h2000, 3'd0, 8'h00, 64'h0,                64'h0,                 1'b1, 1'b0);
    issue(0, 64'h1FFF, 3'd0, 8'h00, 64'h0,                64'h0,                 1'b0, 1'b0);
    issue(0, 64'h0,    3'd4, 8'h00, 64'h0,                64'h0,                 1'b1, 1'b0);
    issue(0, 64'h29,   3'd1, 8'h00, 64'h0,                64'h0,                 1'b1, 1'b0);
    issue(0, 64'h2C,   3'd2, 8'h00, 64'h0,                64'h11223344BBBBBBBB, 1'b0, 1'b0);
    issue(0, 64'h30,   3'd3, 8'hF0, 64'h5566778800000000, 64'h0,                 1'b0, 1'b1);
    issue(0, 64'h30,   3'd3, 8'h00, 64'h0,                64'h5566778800000000, 1'b0, 1'b0);

    // LATENCY=0: back-to-back, store immediately followed by a load of the same word
    issue(1, 64'h8, 3'd3, 8'hFF, 64'h0123456789ABCDEF, 64'h0,                 1'b0, 1'b0);
    issue(1, 64'h8, 3'd3, 8'h00, 64'h0,                64'h0123456789ABCDEF, 1'b0, 1'b0);
    issue(1, 64'h0, 3'd3, 8'h00, 64'h0,                64'h0,                 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // LATENCY=5: reset during WAIT abandons the store
    issue(2, 64'h10, 3'd3, 8'hFF, 64'hA5A5A5A5A5A5A5A5, 64'h0, 1'b0, 1'b0);
    dv[2] = 1'b1; da[2] = 64'h10; ds[2] = 3'd3; dst[2] = 8'hFF; dd[2] = 64'h5A5A5A5A5A5A5A5A;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkZero(2, "reset_in_wait");
    dv[2] = 1'b0;
    dst[2] = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    issue(2, 64'h10, 3'd3, 8'h00, 64'h0, 64'hA5A5A5A5A5A5A5A5, 1'b0, 1'b0);

    for (int k = 0; k < 50 && sbq.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending %0d, required 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
